// File: rtl/ahb_apb_bridge_param.sv
// AHB-Lite to APB bridge with a parameterised slave count and bus widths.
// The bridge decodes an address window starting at BASE_ADDR into NUM_SLV equal slave windows.
// It supports APB wait states through Pready.
// Pslverr, unmapped addresses and a Pready timeout are all reported as a two-cycle AHB ERROR.
module ahb_apb_bridge_param #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                NUM_SLV   = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h8000_0000),
  parameter int                SLV_SHIFT = 10,
  parameter int                TIMEOUT   = 256
) (
  input  logic              Hclk,
  input  logic              Hresetn,
  input  logic              Hwrite,
  input  logic              Hreadyin,
  input  logic [1:0]        Htrans,
  input  logic [ADDR_W-1:0] Haddr,
  input  logic [DATA_W-1:0] Hwdata,
  output logic              Hreadyout,
  output logic [1:0]        Hresp,
  output logic [DATA_W-1:0] Hrdata,
  output logic [NUM_SLV-1:0] Pselx,
  output logic              Penable,
  output logic              Pwrite,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  input  logic [DATA_W-1:0] Prdata,
  input  logic              Pready,
  input  logic              Pslverr
);

  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [ADDR_W:0]  REGION  = (ADDR_W + 1)'(NUM_SLV) << SLV_SHIFT;
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2} state_t;

  state_t            state, next_state, acc_state;
  logic              accept, take, mapped;
  logic [ADDR_W-1:0] offset, addr_q;
  logic [IDX_W-1:0]  idx_q;
  logic [CNT_W-1:0]  cnt;
  logic              htrans_unused;

  assign htrans_unused = Htrans[0];
  assign accept = Htrans[1] && Hreadyin;
  assign offset = Haddr - BASE_ADDR;
  assign mapped = (Haddr >= BASE_ADDR) && ({1'b0, offset} < REGION);
  assign Hrdata = Prdata;

  // Next-state decode plus the AHB response for the current state
  always_comb begin
    next_state = state;
    Hreadyout  = 1'b1;
    Hresp      = 2'b00;
    take       = 1'b0;
    if (!mapped)
      acc_state = ERR1;
    else if (Hwrite)
      acc_state = WDATA;
    else
      acc_state = SETUP;
    case (state)
      IDLE: begin
        if (accept) begin
          take       = 1'b1;
          next_state = acc_state;
        end
      end
      WDATA: begin
        Hreadyout  = 1'b0;
        next_state = SETUP;
      end
      SETUP: begin
        Hreadyout  = 1'b0;
        next_state = ACCESS;
      end
      ACCESS: begin
        Hreadyout = Pready && !Pslverr;
        if (Pready && !Pslverr) begin
          if (accept) begin
            take       = 1'b1;
            next_state = acc_state;
          end else begin
            next_state = IDLE;
          end
        end else if (Pready) begin
          next_state = ERR1;
        end else if ((TIMEOUT > 0) && (cnt == TO_LAST)) begin
          next_state = ERR1;
        end
      end
      ERR1: begin
        Hreadyout  = 1'b0;
        Hresp      = 2'b01;
        next_state = ERR2;
      end
      ERR2: begin
        Hresp = 2'b01;
        if (accept) begin
          take       = 1'b1;
          next_state = acc_state;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // APB select and enable follow the state, so reset or an error drops them at once
  always_comb begin
    Pselx   = '0;
    Penable = 1'b0;
    if (state == SETUP || state == ACCESS)
      Pselx = NUM_SLV'(1) << idx_q;
    if (state == ACCESS)
      Penable = 1'b1;
  end

  // State register
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Address and slave index captured when a transfer is accepted
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      addr_q <= '0;
      idx_q  <= '0;
    end else if (take) begin
      addr_q <= Haddr;
      if (mapped)
        idx_q <= offset[SLV_SHIFT +: IDX_W];
    end
  end

  // APB address, direction and write data, loaded on entry to SETUP and held otherwise
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      Paddr  <= '0;
      Pwrite <= 1'b0;
      Pwdata <= '0;
    end else if (state == WDATA) begin
      Paddr  <= addr_q;
      Pwrite <= 1'b1;
      Pwdata <= Hwdata;
    end else if (take && next_state == SETUP) begin
      Paddr  <= Haddr;
      Pwrite <= 1'b0;
    end
  end

  // Pready timeout counter, cleared on entry to SETUP
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn)
      cnt <= '0;
    else if (next_state == SETUP)
      cnt <= '0;
    else if (state == ACCESS && !Pready)
      cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_ahb_apb_bridge_param.sv
// Directed testbench for ahb_apb_bridge_param.
// The main instance uses the default parameters.
// A second instance with TIMEOUT=4 shares the stimulus and is used for the timeout case.
module tb_ahb_apb_bridge_param;

  logic        Hclk, Hresetn, Hwrite, Hreadyin;
  logic [1:0]  Htrans;
  logic [31:0] Haddr, Hwdata, Prdata;
  logic        Pready, Pslverr;

  logic        Hreadyout, Penable, Pwrite;
  logic [1:0]  Hresp;
  logic [31:0] Hrdata, Paddr, Pwdata;
  logic [2:0]  Pselx;

  logic        toHreadyout, toPenable, toPwrite;
  logic [1:0]  toHresp;
  logic [31:0] toHrdata, toPaddr, toPwdata;
  logic [2:0]  toPselx;

  int checkCount = 0;
  int failCount  = 0;
  int accessLen;

  ahb_apb_bridge_param dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
    .Htrans(Htrans), .Haddr(Haddr), .Hwdata(Hwdata),
    .Hreadyout(Hreadyout), .Hresp(Hresp), .Hrdata(Hrdata),
    .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata),
    .Prdata(Prdata), .Pready(Pready), .Pslverr(Pslverr)
  );

  ahb_apb_bridge_param #(.TIMEOUT(4)) dutTo (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
    .Htrans(Htrans), .Haddr(Haddr), .Hwdata(Hwdata),
    .Hreadyout(toHreadyout), .Hresp(toHresp), .Hrdata(toHrdata),
    .Pselx(toPselx), .Penable(toPenable), .Pwrite(toPwrite), .Paddr(toPaddr), .Pwdata(toPwdata),
    .Prdata(Prdata), .Pready(Pready), .Pslverr(Pslverr)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] trans, input logic write, input logic [31:0] addr, input logic [31:0] wdata);
    Htrans = trans;
    Hwrite = write;
    Haddr  = addr;
    Hwdata = wdata;
  endtask

  task automatic nextCycle;
    @(posedge Hclk);
    #1;
  endtask

  task automatic sample;
    @(negedge Hclk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Hresetn  = 1'b0;
    Hreadyin = 1'b1;
    Prdata   = '0;
    Pready   = 1'b1;
    Pslverr  = 1'b0;
    applyStimulus(2'b00, 1'b0, 32'h0, 32'h0);

    // reset state
    sample;
    checkOutput("rst_ready",   Hreadyout, 1);
    checkOutput("rst_hresp",   Hresp,     0);
    checkOutput("rst_psel",    Pselx,     0);
    checkOutput("rst_penable", Penable,   0);
    checkOutput("rst_paddr",   Paddr,     0);
    checkOutput("rst_pwrite",  Pwrite,    0);
    checkOutput("rst_pwdata",  Pwdata,    0);
    nextCycle;
    Hresetn = 1'b1;

    // read slave 1, no wait states
    applyStimulus(2'b10, 1'b0, 32'h8000_0404, 32'h0);
    Prdata = 32'hDEAD_BEEF;
    sample;
    checkOutput("rd_addr_ready", Hreadyout, 1);
    nextCycle;
    applyStimulus(2'b00, 1'b0, 32'h0, 32'h0);
    sample;
    checkOutput("rd_setup_psel",    Pselx,     3'b010);
    checkOutput("rd_setup_penable", Penable,   0);
    checkOutput("rd_setup_ready",   Hreadyout, 0);
    checkOutput("rd_setup_paddr",   Paddr,     32'h8000_0404);
    nextCycle;
    sample;
    checkOutput("rd_access_psel",    Pselx,     3'b010);
    checkOutput("rd_access_penable", Penable,   1);
    checkOutput("rd_access_ready",   Hreadyout, 1);
    checkOutput("rd_access_hrdata",  Hrdata,    32'hDEAD_BEEF);
    checkOutput("rd_access_hresp",   Hresp,     0);
    nextCycle;
    sample;
    checkOutput("rd_idle_psel",    Pselx,   0);
    checkOutput("rd_idle_penable", Penable, 0);
    checkOutput("rd_idle_paddr",   Paddr,   32'h8000_0404);

    // write slave 0 with three wait states
    nextCycle;
    applyStimulus(2'b10, 1'b1, 32'h8000_0008, 32'h0);
    nextCycle;
    applyStimulus(2'b00, 1'b0, 32'h0, 32'h1234_5678);
    sample;
    checkOutput("wr_wdata_ready", Hreadyout, 0);
    checkOutput("wr_wdata_psel",  Pselx,     0);
    nextCycle;
    Hwdata = 32'hFFFF_FFFF;
    Pready = 1'b0;
    sample;
    checkOutput("wr_setup_psel",    Pselx,   3'b001);
    checkOutput("wr_setup_penable", Penable, 0);
    checkOutput("wr_setup_pwdata",  Pwdata,  32'h1234_5678);
    checkOutput("wr_setup_paddr",   Paddr,   32'h8000_0008);
    checkOutput("wr_setup_pwrite",  Pwrite,  1);
    nextCycle;
    for (int i = 0; i < 4; i++) begin
      Pready = (i == 3);
      sample;
      checkOutput("wr_acc_penable", Penable,   1);
      checkOutput("wr_acc_ready",   Hreadyout, (i == 3));
      checkOutput("wr_acc_pwdata",  Pwdata,    32'h1234_5678);
      checkOutput("wr_acc_hresp",   Hresp,     0);
      nextCycle;
    end
    Pready = 1'b1;
    sample;
    checkOutput("wr_done_psel",    Pselx,   0);
    checkOutput("wr_done_penable", Penable, 0);

    // back-to-back write then read at slave 2
    nextCycle;
    applyStimulus(2'b10, 1'b1, 32'h8000_0800, 32'h0);
    nextCycle;
    applyStimulus(2'b10, 1'b0, 32'h8000_0800, 32'hA5A5_0001);
    sample;
    checkOutput("b2b_wdata_ready", Hreadyout, 0);
    nextCycle;
    sample;
    checkOutput("b2b_wsetup_psel",   Pselx,  3'b100);
    checkOutput("b2b_wsetup_pwrite", Pwrite, 1);
    checkOutput("b2b_wsetup_pwdata", Pwdata, 32'hA5A5_0001);
    nextCycle;
    sample;
    checkOutput("b2b_waccess_ready",  Hreadyout, 1);
    checkOutput("b2b_waccess_pwrite", Pwrite,    1);
    checkOutput("b2b_waccess_paddr",  Paddr,     32'h8000_0800);
    nextCycle;
    applyStimulus(2'b00, 1'b0, 32'h0, 32'h0);
    Prdata = 32'h0BAD_F00D;
    sample;
    checkOutput("b2b_rsetup_psel",    Pselx,   3'b100);
    checkOutput("b2b_rsetup_penable", Penable, 0);
    checkOutput("b2b_rsetup_pwrite",  Pwrite,  0);
    nextCycle;
    sample;
    checkOutput("b2b_raccess_ready",  Hreadyout, 1);
    checkOutput("b2b_raccess_hrdata", Hrdata,    32'h0BAD_F00D);

    // slave error on a read
    nextCycle;
    applyStimulus(2'b10, 1'b0, 32'h8000_0000, 32'h0);
    nextCycle;
    applyStimulus(2'b00, 1'b0, 32'h0, 32'h0);
    Pslverr = 1'b1;
    sample;
    checkOutput("se_setup_psel", Pselx, 3'b001);
    nextCycle;
    sample;
    checkOutput("se_access_ready", Hreadyout, 0);
    checkOutput("se_access_hresp", Hresp,     0);
    nextCycle;
    Pslverr = 1'b0;
    sample;
    checkOutput("se_err1_ready", Hreadyout, 0);
    checkOutput("se_err1_hresp", Hresp,     1);
    checkOutput("se_err1_psel",  Pselx,     0);
    nextCycle;
    sample;
    checkOutput("se_err2_ready", Hreadyout, 1);
    checkOutput("se_err2_hresp", Hresp,     1);
    nextCycle;
    sample;
    checkOutput("se_idle_hresp", Hresp, 0);

    // unmapped address, then first address past the region, then last mapped word
    nextCycle;
    applyStimulus(2'b10, 1'b0, 32'h0000_1000, 32'h0);
    nextCycle;
    applyStimulus(2'b00, 1'b0, 32'h0, 32'h0);
    sample;
    checkOutput("um_err1_ready", Hreadyout, 0);
    checkOutput("um_err1_hresp", Hresp,     1);
    checkOutput("um_err1_psel",  Pselx,     0);
    nextCycle;
    applyStimulus(2'b10, 1'b1, 32'h8000_0C00, 32'h0);
    sample;
    checkOutput("um_err2_ready", Hreadyout, 1);
    checkOutput("um_err2_hresp", Hresp,     1);
    nextCycle;
    applyStimulus(2'b00, 1'b0, 32'h0, 32'h0);
    sample;
    checkOutput("end_err1_ready", Hreadyout, 0);
    checkOutput("end_err1_hresp", Hresp,     1);
    checkOutput("end_err1_psel",  Pselx,     0);
    nextCycle;
    applyStimulus(2'b10, 1'b0, 32'h8000_0BFC, 32'h0);
    sample;
    checkOutput("end_err2_hresp", Hresp, 1);
    nextCycle;
    applyStimulus(2'b00, 1'b0, 32'h0, 32'h0);
    sample;
    checkOutput("last_setup_psel",  Pselx, 3'b100);
    checkOutput("last_setup_paddr", Paddr, 32'h8000_0BFC);
    nextCycle;
    sample;
    checkOutput("last_access_ready", Hreadyout, 1);

    // Pready stuck low: the TIMEOUT=4 instance errors, the default one keeps waiting
    nextCycle;
    applyStimulus(2'b10, 1'b0, 32'h8000_0400, 32'h0);
    Pready = 1'b0;
    nextCycle;
    applyStimulus(2'b00, 1'b0, 32'h0, 32'h0);
    nextCycle;
    accessLen = 0;
    for (int i = 0; i < 20; i++) begin
      sample;
      if (!toPenable) break;
      accessLen++;
      nextCycle;
    end
    checkOutput("to_access_len", accessLen,   4);
    checkOutput("to_err1_hresp", toHresp,     1);
    checkOutput("to_err1_ready", toHreadyout, 0);
    checkOutput("to_err1_psel",  toPselx,     0);
    nextCycle;
    sample;
    checkOutput("to_err2_ready",      toHreadyout, 1);
    checkOutput("to_err2_hresp",      toHresp,     1);
    checkOutput("main_wait_penable",  Penable,     1);
    checkOutput("main_wait_psel",     Pselx,       3'b010);

    // asynchronous reset in the middle of ACCESS
    #2;
    Hresetn = 1'b0;
    #1;
    checkOutput("arst_psel",    Pselx,     0);
    checkOutput("arst_penable", Penable,   0);
    checkOutput("arst_paddr",   Paddr,     0);
    checkOutput("arst_pwdata",  Pwdata,    0);
    checkOutput("arst_pwrite",  Pwrite,    0);
    checkOutput("arst_ready",   Hreadyout, 1);
    checkOutput("arst_hresp",   Hresp,     0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
